// File: rtl/ff_pkg.sv
// Shared constants for the T-flop based counter family.
package ff_pkg;
  localparam logic CNT_UP        = 1'b1;
  localparam logic CNT_DN        = 1'b0;
  localparam int   CNT_MAX_WIDTH = 32'sd32;
endpackage

// File: rtl/t_ff_cell.sv
// Single T flip-flop: toggles when t is high, async active-low reset to rst_val.
module t_ff_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic rst_val,
  input  logic t,
  output logic q,
  output logic qn
);

  logic q_r;

  // toggle storage; q and qn both come from this one flop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r <= rst_val;
    end else begin
      q_r <= q_r ^ t;
    end
  end

  assign q  = q_r;
  assign qn = ~q_r;

endmodule

// File: rtl/tff_sync_counter.sv
// Synchronous up/down modulus-N counter built from a bank of T flip-flop cells.
// The next count is formed in WIDTH+1-bit arithmetic and applied as per-bit toggles.
module tff_sync_counter
  import ff_pkg::*;
#(
  parameter int     WIDTH     = 32'sd8,
  parameter longint MODULUS   = 64'sd256,
  parameter longint RESET_VAL = 64'sd0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic             tc,
  output logic             wrap,
  output logic             load_err
);

  generate
    if ((WIDTH < 32'sd1) || (WIDTH > CNT_MAX_WIDTH) || (MODULUS < 64'sd2) ||
        (MODULUS > (64'sd1 <<< WIDTH)) || (RESET_VAL < 64'sd0) ||
        (RESET_VAL >= MODULUS)) begin : g_param_err
      $error("tff_sync_counter: illegal WIDTH/MODULUS/RESET_VAL combination");
    end
  endgenerate

  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);
  localparam logic [WIDTH-1:0] MOD_MAX = WIDTH'(MODULUS - 64'sd1);
  localparam logic [WIDTH-1:0] RST_Q   = WIDTH'(RESET_VAL);
  localparam logic [WIDTH:0]   ONE_EXT = {{WIDTH{1'b0}}, 1'b1};

  logic [WIDTH-1:0] q_s;
  logic [WIDTH-1:0] qn_s;
  logic [WIDTH-1:0] next_s;
  logic [WIDTH-1:0] t_s;
  logic [WIDTH:0]   q_ext_s;
  logic [WIDTH:0]   ld_ext_s;
  logic [WIDTH:0]   inc_s;
  logic [WIDTH:0]   dec_s;
  logic             load_clip_s;
  logic             tc_s;
  logic             wrap_r;
  logic             load_err_r;

  // The extra top bit makes the up-wrap compare and down-borrow exact even at MODULUS == 2**WIDTH.
  assign q_ext_s     = {1'b0, q_s};
  assign ld_ext_s    = {1'b0, load_val};
  assign inc_s       = q_ext_s + ONE_EXT;
  assign dec_s       = q_ext_s - ONE_EXT;
  assign load_clip_s = (ld_ext_s >= MOD_EXT);

  // next-count selection: clr > load > en > hold
  always_comb begin
    next_s = q_s;
    if (clr) begin
      next_s = {WIDTH{1'b0}};
    end else if (load) begin
      if (load_clip_s) begin
        next_s = MOD_MAX;
      end else begin
        next_s = load_val;
      end
    end else if (en) begin
      if (up_dn == CNT_UP) begin
        if (inc_s == MOD_EXT) begin
          next_s = {WIDTH{1'b0}};
        end else begin
          next_s = inc_s[WIDTH-1:0];
        end
      end else begin
        if (dec_s[WIDTH]) begin
          next_s = MOD_MAX;
        end else begin
          next_s = dec_s[WIDTH-1:0];
        end
      end
    end else begin
      next_s = q_s;
    end
  end

  // terminal count: counting this cycle and sitting on the wrap boundary for the direction
  always_comb begin
    tc_s = 1'b0;
    if (en && !clr && !load) begin
      if (up_dn == CNT_UP) begin
        tc_s = (q_s == MOD_MAX);
      end else begin
        tc_s = (q_s == {WIDTH{1'b0}});
      end
    end else begin
      tc_s = 1'b0;
    end
  end

  assign t_s = next_s ^ q_s;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    t_ff_cell u_cell (
      .clk     (clk),
      .rst_n   (rst_n),
      .rst_val (RST_Q[i]),
      .t       (t_s[i]),
      .q       (q_s[i]),
      .qn      (qn_s[i])
    );
  end

  // one-cycle status pulses following a wrap or a clipped load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrap_r     <= 1'b0;
      load_err_r <= 1'b0;
    end else begin
      wrap_r     <= tc_s;
      load_err_r <= !clr && load && load_clip_s;
    end
  end

  assign q        = q_s;
  assign qn       = qn_s;
  assign tc       = tc_s;
  assign wrap     = wrap_r;
  assign load_err = load_err_r;

endmodule

// File: tb/tb_tff_sync_counter.sv
// Bench for tff_sync_counter: directed vector table on a mod-10 instance, random and
// full-range scoreboard runs against a modular-arithmetic reference model.
module tb_tff_sync_counter;

  localparam int AW = 4;
  localparam int AM = 10;
  localparam int AR = 3;
  localparam int BW = 8;
  localparam int BM = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n_a, en_a, up_a, clr_a, load_a, tc_a, wrap_a, le_a;
  logic [AW-1:0] lv_a, q_a, qn_a;
  logic          rst_n_b, en_b, up_b, clr_b, load_b, tc_b, wrap_b, le_b;
  logic [BW-1:0] lv_b, q_b, qn_b;

  tff_sync_counter #(.WIDTH(AW), .MODULUS(AM), .RESET_VAL(AR)) dut_a (
    .clk(clk), .rst_n(rst_n_a), .en(en_a), .up_dn(up_a), .clr(clr_a), .load(load_a),
    .load_val(lv_a), .q(q_a), .qn(qn_a), .tc(tc_a), .wrap(wrap_a), .load_err(le_a)
  );

  tff_sync_counter #(.WIDTH(BW), .MODULUS(BM), .RESET_VAL(0)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .en(en_b), .up_dn(up_b), .clr(clr_b), .load(load_b),
    .load_val(lv_b), .q(q_b), .qn(qn_b), .tc(tc_b), .wrap(wrap_b), .load_err(le_b)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: counting is plain modular arithmetic on integers.
  function automatic int unsigned mdl_next(input int unsigned cur, input int unsigned m,
                                           input bit c, input bit l, input bit e, input bit u,
                                           input int unsigned lv);
    if (c) return 0;
    if (l) return (lv < m) ? lv : m - 1;
    if (e) return u ? (cur + 1) % m : (cur + m - 1) % m;
    return cur;
  endfunction

  function automatic bit mdl_tc(input int unsigned cur, input int unsigned m,
                                input bit c, input bit l, input bit e, input bit u);
    return e && !c && !l && (u ? (cur == m - 1) : (cur == 0));
  endfunction

  typedef struct {
    bit clr, load, en, up;
    int unsigned lv;
    int unsigned q;
    bit tc, wrap, le;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input bit c, input bit l, input bit e, input bit u,
                              input int unsigned lv, input int unsigned q,
                              input bit tc, input bit w, input bit le);
    vec_t v;
    v.clr = c; v.load = l; v.en = e; v.up = u; v.lv = lv;
    v.q = q; v.tc = tc; v.wrap = w; v.le = le;
    return v;
  endfunction

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout time=%0t", $time);
    $fatal(1, "bench did not finish in time");
  end

  initial begin : main
    logic [AW-1:0] ea, ena;
    logic [BW-1:0] eb, enb;
    int unsigned   ma_q, mb_q;
    bit            tca_exp, tcb_exp, lea_exp, leb_exp;
    int            wrap_cnt;

    rst_n_a = 1'b0; en_a = 1'b0; up_a = 1'b1; clr_a = 1'b0; load_a = 1'b0; lv_a = '0;
    rst_n_b = 1'b0; en_b = 1'b0; up_b = 1'b1; clr_b = 1'b0; load_b = 1'b0; lv_b = '0;

    // clr, load, en, up, load_val -> q, tc, wrap, load_err (mod 10, starting at q=3)
    vecs.push_back(mk(0,1,1,1, 8,  8,0,0,0));
    vecs.push_back(mk(0,0,1,1, 0,  9,0,0,0));
    vecs.push_back(mk(0,0,1,1, 0,  0,1,1,0));
    vecs.push_back(mk(0,0,1,1, 0,  1,0,0,0));
    vecs.push_back(mk(0,0,1,0, 0,  0,0,0,0));
    vecs.push_back(mk(0,0,1,0, 0,  9,1,1,0));
    vecs.push_back(mk(0,0,1,0, 0,  8,0,0,0));
    vecs.push_back(mk(0,1,0,0, 5,  5,0,0,0));
    vecs.push_back(mk(0,0,1,1, 0,  6,0,0,0));
    vecs.push_back(mk(0,0,1,0, 0,  5,0,0,0));
    vecs.push_back(mk(0,0,1,1, 0,  6,0,0,0));
    vecs.push_back(mk(0,1,1,1, 7,  7,0,0,0));
    vecs.push_back(mk(0,1,0,1, 9,  9,0,0,0));
    vecs.push_back(mk(1,1,1,1, 7,  0,0,0,0));
    vecs.push_back(mk(0,1,1,0, 0,  0,0,0,0));
    vecs.push_back(mk(0,1,1,1, 12, 9,0,0,1));
    vecs.push_back(mk(0,0,0,1, 0,  9,0,0,0));
    vecs.push_back(mk(0,1,0,1, 10, 9,0,0,1));
    vecs.push_back(mk(0,1,0,1, 15, 9,0,0,1));
    vecs.push_back(mk(1,1,0,1, 14, 0,0,0,0));
    vecs.push_back(mk(0,1,0,1, 4,  4,0,0,0));
    for (int i = 0; i < 5; i++) vecs.push_back(mk(0,0,0,i[0],0, 4,0,0,0));

    repeat (2) @(posedge clk);
    #1;
    check("rst_q_a", q_a, AR);
    check("rst_qn_a", qn_a, 4'hC);
    check("rst_wrap_a", wrap_a, 0);
    check("rst_lerr_a", le_a, 0);
    check("rst_q_b", q_b, 0);
    check("rst_qn_b", qn_b, 8'hFF);
    @(negedge clk);
    rst_n_a = 1'b1; rst_n_b = 1'b1;
    @(posedge clk);
    #1;
    check("release_hold_a", q_a, AR);

    foreach (vecs[i]) begin
      clr_a = vecs[i].clr; load_a = vecs[i].load; en_a = vecs[i].en; up_a = vecs[i].up;
      lv_a = AW'(vecs[i].lv);
      #1;
      check($sformatf("vec%0d_tc", i), tc_a, vecs[i].tc);
      @(posedge clk);
      #1;
      ea = AW'(vecs[i].q);
      ena = ~ea;
      check($sformatf("vec%0d_q", i), q_a, ea);
      check($sformatf("vec%0d_qn", i), qn_a, ena);
      check($sformatf("vec%0d_wrap", i), wrap_a, vecs[i].wrap);
      check($sformatf("vec%0d_lerr", i), le_a, vecs[i].le);
    end

    // wrap, then async reset mid-cycle while still counting
    clr_a = 1'b0; load_a = 1'b1; lv_a = 4'd9; en_a = 1'b0; up_a = 1'b1;
    @(posedge clk);
    #1;
    load_a = 1'b0; en_a = 1'b1;
    @(posedge clk);
    #1;
    check("pre_rst_wrap_a", wrap_a, 1);
    #3;
    rst_n_a = 1'b0;
    #1;
    check("async_rst_q_a", q_a, AR);
    check("async_rst_qn_a", qn_a, 4'hC);
    check("async_rst_wrap_a", wrap_a, 0);
    @(posedge clk);
    #1;
    check("rst_held_q_a", q_a, AR);
    @(negedge clk);
    rst_n_a = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_count_a", q_a, AR + 1);

    // common starting point for the random phase
    en_a = 1'b0; clr_a = 1'b1; clr_b = 1'b1;
    @(posedge clk);
    #1;
    check("clr_q_a", q_a, 0);
    check("clr_q_b", q_b, 0);
    ma_q = 0; mb_q = 0;

    for (int n = 0; n < 400; n++) begin
      clr_a  = ($urandom_range(15) == 0); load_a = ($urandom_range(7) == 0);
      en_a   = ($urandom_range(3) != 0);  up_a   = $urandom_range(1);
      lv_a   = AW'($urandom_range(15));
      clr_b  = ($urandom_range(15) == 0); load_b = ($urandom_range(7) == 0);
      en_b   = ($urandom_range(3) != 0);  up_b   = $urandom_range(1);
      lv_b   = BW'($urandom_range(255));
      #1;
      tca_exp = mdl_tc(ma_q, AM, clr_a, load_a, en_a, up_a);
      tcb_exp = mdl_tc(mb_q, BM, clr_b, load_b, en_b, up_b);
      lea_exp = !clr_a && load_a && (lv_a >= AM);
      leb_exp = !clr_b && load_b && (lv_b >= BM);
      check("rnd_tc_a", tc_a, tca_exp);
      check("rnd_tc_b", tc_b, tcb_exp);
      ma_q = mdl_next(ma_q, AM, clr_a, load_a, en_a, up_a, lv_a);
      mb_q = mdl_next(mb_q, BM, clr_b, load_b, en_b, up_b, lv_b);
      @(posedge clk);
      #1;
      ea = AW'(ma_q); ena = ~ea;
      eb = BW'(mb_q); enb = ~eb;
      check("rnd_q_a", q_a, ea);
      check("rnd_qn_a", qn_a, ena);
      check("rnd_wrap_a", wrap_a, tca_exp);
      check("rnd_lerr_a", le_a, lea_exp);
      check("rnd_q_b", q_b, eb);
      check("rnd_qn_b", qn_b, enb);
      check("rnd_wrap_b", wrap_b, tcb_exp);
      check("rnd_lerr_b", le_b, leb_exp);
    end

    // full-range run: 300 up counts from 0 on the 8-bit natural-rollover instance
    en_a = 1'b0; clr_a = 1'b0; load_a = 1'b0;
    clr_b = 1'b1; load_b = 1'b0; en_b = 1'b0;
    @(posedge clk);
    #1;
    clr_b = 1'b0; en_b = 1'b1; up_b = 1'b1;
    mb_q = 0;
    wrap_cnt = 0;
    for (int n = 0; n < 300; n++) begin
      tcb_exp = mdl_tc(mb_q, BM, 1'b0, 1'b0, 1'b1, 1'b1);
      mb_q = mdl_next(mb_q, BM, 1'b0, 1'b0, 1'b1, 1'b1, 0);
      @(posedge clk);
      #1;
      if (wrap_b === 1'b1) wrap_cnt++;
      eb = BW'(mb_q);
      check("full_q_b", q_b, eb);
      check("full_wrap_b", wrap_b, tcb_exp);
    end
    check("full_final_q_b", q_b, 44);
    check("full_wrap_count_b", wrap_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
